// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment encodings,
// bit ordering and counter sizing.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Bit positions within the active-low {a,b,c,d,e,f,g} segment vector
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    // Width of a counter that runs 0..n-1 (never below one bit)
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seven_seg_encoder.sv
// Combinational BCD-to-segment decoder; codes 10..15 produce a blank digit.
module seven_seg_encoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (code == i[3:0]) seg = SEG_TABLE[i];
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode display driver with frame-coherent input
// snapshot, per-digit blank/blink, decimal points and an inter-digit guard.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   blink,
    output logic [6:0]              segments,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   anode_active
);

    localparam int PW = cnt_width(REFRESH_DIV);
    localparam int IW = cnt_width(NUM_DIGITS);
    localparam int FW = cnt_width(BLINK_FRAMES);
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FCNT_MAX  = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic [FW-1:0] fcnt;
    logic          blink_phase;

    logic [4*NUM_DIGITS-1:0] snap_bcd;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic [NUM_DIGITS-1:0]   snap_blink;

    logic                  slot_end;
    logic                  frame_start;
    logic [3:0]            cur_code;
    logic                  cur_dp;
    logic                  cur_dark;
    logic [NUM_DIGITS-1:0] anode_sel;
    logic [6:0]            cur_seg;
    logic [6:0]            seg_nxt;
    logic                  dpn_nxt;
    logic [NUM_DIGITS-1:0] anode_nxt;

    assign slot_end    = (presc == PRESC_MAX);
    assign frame_start = (presc == '0) && (idx == '0);

    // Scan counters; disabling restarts the scan and the blink cadence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            idx         <= '0;
            fcnt        <= '0;
            blink_phase <= 1'b0;
        end else if (!en) begin
            presc       <= '0;
            idx         <= '0;
            fcnt        <= '0;
            blink_phase <= 1'b0;
        end else if (slot_end) begin
            presc <= '0;
            if (idx == IDX_MAX) begin
                idx <= '0;
                if (fcnt == FCNT_MAX) begin
                    fcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end else begin
                idx <= idx + IW'(1);
            end
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Inputs are sampled once per frame so a frame is never torn
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_bcd   <= '0;
            snap_dp    <= '0;
            snap_blank <= '0;
            snap_blink <= '0;
        end else if (en && frame_start) begin
            snap_bcd   <= digits_bcd;
            snap_dp    <= dp;
            snap_blank <= blank;
            snap_blink <= blink;
        end
    end

    always_comb begin
        cur_code  = '0;
        cur_dp    = 1'b0;
        cur_dark  = 1'b1;
        anode_sel = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == i[IW-1:0]) begin
                cur_code     = snap_bcd[4*i +: 4];
                cur_dp       = snap_dp[i];
                cur_dark     = snap_blank[i] | (snap_blink[i] & blink_phase);
                anode_sel[i] = 1'b0;
            end
        end
    end

    seven_seg_encoder u_enc (
        .code (cur_code),
        .seg  (cur_seg)
    );

    // presc==0 is the guard slot that keeps adjacent anodes from overlapping
    always_comb begin
        anode_nxt = '1;
        seg_nxt   = SEG_BLANK;
        dpn_nxt   = 1'b1;
        if (en && (presc != '0) && !cur_dark) begin
            anode_nxt = anode_sel;
            seg_nxt   = cur_seg;
            dpn_nxt   = ~cur_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_active <= '1;
            segments     <= SEG_BLANK;
            dp_n         <= 1'b1;
        end else begin
            anode_active <= anode_nxt;
            segments     <= seg_nxt;
            dp_n         <= dpn_nxt;
        end
    end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Time-multiplexed driver for a common-anode seven-segment display with NUM_DIGITS positions. It is the parametrised successor of the single-digit segment/anode decoder and owns the scan counter that the decoder previously received from outside. It also provides per-digit blanking, per-digit blink, decimal points, a one-cycle anti-ghosting guard, and frame-coherent input capture. It sits between the clock/alarm time-keeping logic and the board display pins.

## Interface
- NUM_DIGITS, 4, number of display positions (1..8)
- REFRESH_DIV, 100000, clk cycles per digit slot (≥2)
- BLINK_FRAMES, 64, complete scan frames per blink half-period (≥1)
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  display enable; low forces display dark and restarts scan
- digits_bcd  input  4*NUM_DIGITS  digit i code in bits [4i+3:4i]; digit 0 is rightmost
- dp  input  NUM_DIGITS  decimal point request per digit, active-high
- blank  input  NUM_DIGITS  force digit dark, active-high
- blink  input  NUM_DIGITS  digit dark during blink-off phase, active-high
- segments  output  7  active-low segments {a,b,c,d,e,f,g}, a = MSB
- dp_n  output  1  active-low decimal point
- anode_active  output  NUM_DIGITS  active-low anode enables, bit i = digit i

## Operation
- State: prescaler presc (0..REFRESH_DIV-1), slot index idx (0..NUM_DIGITS-1), frame counter fcnt (0..BLINK_FRAMES-1), blink_phase, snapshot registers for digits_bcd/dp/blank/blink.
- presc increments every cycle when en=1. At REFRESH_DIV-1 it wraps to 0 and idx advances. idx wraps from NUM_DIGITS-1 to 0.
- Frame end (presc wrap with idx=NUM_DIGITS-1): fcnt increments. When fcnt wraps, blink_phase toggles.
- Snapshot loads from inputs in every cycle with en=1, presc=0, idx=0. Input changes elsewhere in a frame take effect only at the next frame start, so the display never shows a torn frame.
- Encoding, codes 0..9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100. Codes 10..15 map to 1111111.
- Digit i is dark when snapshot blank[i]=1, or when snapshot blink[i]=1 and blink_phase=1.
- Dark digit: anode_active all 1, segments 1111111, dp_n 1.
- Guard: while presc=0, all anodes are off, segments are 1111111 and dp_n is 1.
- Lit digit in presc 1..REFRESH_DIV-1: anode_active has only bit idx low, segments = encode(code), dp_n = ~dp[idx].
- When en=0, all counters, blink_phase and fcnt are cleared synchronously and outputs go dark. The snapshot is retained. Re-enabling restarts at slot 0 with a fresh snapshot.

## Timing
- All outputs are registered. An output at edge t+1 reflects the state (idx, presc, snapshot) during cycle t, giving 1-cycle latency.
- Reset values: anode_active all 1, segments 1111111, dp_n 1, presc 0, idx 0, fcnt 0, blink_phase 0, snapshot 0.
- After rst_n rises, cycle 0 is a guard and captures the snapshot. Digit 0 lights at the second rising edge and stays lit for REFRESH_DIV-1 cycles.
- Frame length is NUM_DIGITS*REFRESH_DIV cycles. The blink half-period is BLINK_FRAMES frames.
- If en falls mid-slot, outputs are dark at the next edge.
- If rst_n is asserted mid-operation, outputs go dark immediately (asynchronous reset).
- The anode enable never overlaps between adjacent digits: at least one all-off cycle separates them.

## Structure
- Package seven_seg_pkg holds:
  - SEG_BLANK = 7'b1111111;
  - the digit-code-to-segment constant table;
  - segment bit-order constants;
  - a function that computes the idx/presc counter width.
- Sub-module seven_seg_encoder: purely combinational, 4-bit code in, 7-bit active-low segments out, 10..15 blank. It is instantiated once on the muxed snapshot digit.
- Top level holds the counters, snapshot, dark/guard logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
- Reset: hold rst_n=0 with digits_bcd=16'h1234, en=1 → anode_active=1111, segments=1111111, dp_n=1. After release, edge 2 gives anode 1110 and segments 1001100 for 3 cycles, then a guard cycle, then 1101 with 0000110.
- Frame coherence: change digits_bcd from 16'h1234 to 16'h5678 during slot 2 → slots 2 and 3 still show 2 and 1. The next frame shows 8 (0000000) on anode 1110.
- Blink: set blink=0001 → digit 0 is lit in frames 0-1, dark in frames 2-3, lit in frames 4-5. Digits 1..3 are unaffected.
- Blank, invalid code and dp: blank=0010, digit 2 code 4'hC, dp=1000 → slot 1 all anodes off. Slot 2 has anode 1011 with segments 1111111. Slot 3 has dp_n=0.
- Enable: drop en in the middle of slot 1 → next edge is all dark. Raising en restarts at slot 0 with guard then digit 0 and fresh snapshot; blink_phase=0.
- Asynchronous reset mid-slot: assert rst_n=0 between clock edges → outputs go dark without a clock edge, and counters are 0 on release.
